signal_prescaler: RTL

- Runtime-programmable prescaler for the measured input of the frequency meter. It is the successor to the fixed divide-by-16 input divider.
- Synchronises the asynchronous signal_in into the system clk domain and divides it by 2^active_sel, giving a 50 % duty output. active_sel=0 is bypass.
- Ratio changes apply only at output-period boundaries, so the gate counter never sees a runt pulse.
- Also reports input loss (no edges) and out-of-range ratio requests.

---
 rtl/freq_meter_pkg.sv | 27 ++
 rtl/sync_edge_detect.sv | 31 +++
 rtl/signal_prescaler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants and helpers for the frequency-meter input path.
// The prescaler and the gate-signal path both import this package.
package freq_meter_pkg;

    localparam int MAX_SEL_DEF     = 8;
    localparam int DEFAULT_SEL_DEF = 4;
    localparam int LOST_CYCLES_DEF = 50_000_000;

    // What the divider does with its phase state in a given clk cycle.
    typedef enum logic [2:0] {
        STEP_IDLE,
        STEP_CLEAR,
        STEP_RESTART,
        STEP_BYPASS,
        STEP_COUNT
    } step_e;

    function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned max_sel);
        return (sel > max_sel) ? max_sel : sel;
    endfunction

    // Input rising edges per output half-period, minus one, for log2 ratio k.
    function automatic int unsigned half_minus1(input int unsigned k);
        return (k == 0) ? 0 : (32'd1 << (k - 1)) - 1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Three-flop synchroniser for an asynchronous input, with rise/fall strobes
// taken between the second and third stages.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q    = sync_q[2];
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/signal_prescaler.sv
// Runtime-programmable 2^k prescaler for the frequency-meter input, with
// glitch-free ratio changes, input-loss detection and range flagging.
module signal_prescaler
    import freq_meter_pkg::*;
#(
    parameter int MAX_SEL     = MAX_SEL_DEF,
    parameter int SEL_W       = 4,
    parameter int DEFAULT_SEL = DEFAULT_SEL_DEF,
    parameter int LOST_CYCLES = LOST_CYCLES_DEF,
    parameter int LOST_W      = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             signal_in,
    input  logic [SEL_W-1:0] div_sel,
    output logic             div_out,
    output logic             out_rise,
    output logic [SEL_W-1:0] active_sel,
    output logic             sig_lost,
    output logic             sel_err
);

    localparam int CNT_W = (MAX_SEL > 1) ? MAX_SEL - 1 : 1;
    localparam logic [LOST_W-1:0] LOST_LIM = LOST_W'(LOST_CYCLES);

    logic             sync_s3;
    logic             in_rise;
    logic             fall_unused;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              div_out_q, div_out_d;
    logic              out_rise_q, out_rise_d;
    logic [SEL_W-1:0]  active_sel_q, active_sel_d;
    logic [LOST_W-1:0] loss_q, loss_d;
    logic              sig_lost_q, sig_lost_d;
    logic              sel_err_q, sel_err_d;

    logic [SEL_W-1:0]  req;
    logic [CNT_W-1:0]  half_m1;
    logic              bypass;
    logic              boundary;
    step_e             step;

    // The fall strobe is only consumed by the gate-signal path.
    sync_edge_detect u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (signal_in),
        .q    (sync_s3),
        .rise (in_rise),
        .fall (fall_unused)
    );

    always_comb begin
        req       = SEL_W'(clamp_sel(32'(div_sel), MAX_SEL));
        sel_err_d = 32'(div_sel) > 32'(MAX_SEL);
        half_m1   = CNT_W'(half_minus1(32'(active_sel_q)));
        bypass    = (active_sel_q == '0);
        // A ratio may only switch where the output is low and the phase is at its start.
        boundary  = bypass ? ~sync_s3 : (~div_out_q && (cnt_q == '0) && ~in_rise);
        loss_d    = loss_q;
        sig_lost_d = sig_lost_q;
        step      = STEP_IDLE;
        if (!en) begin
            loss_d     = '0;
            sig_lost_d = 1'b0;
            step       = STEP_CLEAR;
        end else begin
            if (in_rise) begin
                loss_d = '0;
            end else if (loss_q != LOST_LIM) begin
                loss_d = loss_q + LOST_W'(1);
            end
            sig_lost_d = (loss_d == LOST_LIM);
            if (sig_lost_d || ((req != active_sel_q) && boundary)) begin
                step = STEP_RESTART;
            end else if (bypass) begin
                step = STEP_BYPASS;
            end else if (in_rise) begin
                step = STEP_COUNT;
            end
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        div_out_d    = div_out_q;
        active_sel_d = active_sel_q;
        unique case (step)
            STEP_CLEAR, STEP_RESTART: begin
                cnt_d        = '0;
                div_out_d    = 1'b0;
                active_sel_d = req;
            end
            STEP_BYPASS: begin
                cnt_d     = '0;
                div_out_d = sync_s3;
            end
            STEP_COUNT: begin
                if (cnt_q == half_m1) begin
                    cnt_d     = '0;
                    div_out_d = ~div_out_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
        out_rise_d = div_out_d & ~div_out_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            div_out_q    <= 1'b0;
            out_rise_q   <= 1'b0;
            active_sel_q <= SEL_W'(DEFAULT_SEL);
            loss_q       <= '0;
            sig_lost_q   <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            div_out_q    <= div_out_d;
            out_rise_q   <= out_rise_d;
            active_sel_q <= active_sel_d;
            loss_q       <= loss_d;
            sig_lost_q   <= sig_lost_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign div_out    = div_out_q;
    assign out_rise   = out_rise_q;
    assign active_sel = active_sel_q;
    assign sig_lost   = sig_lost_q;
    assign sel_err    = sel_err_q;

endmodule
